// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch channel: held request/address out, ready/data back.
interface if_fetch_stage_if;
    logic        Imem_Req;
    logic [31:0] PC_out;
    logic        Imem_Ready;
    logic [31:0] Imem_Rdata;

    modport master (output Imem_Req, output PC_out, input Imem_Ready, input Imem_Rdata);
    modport slave  (input Imem_Req, input PC_out, output Imem_Ready, output Imem_Rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, held imem handshake and IF/ID register.
// Absorbs stalls via a one-entry skid and parks redirects that land on an outstanding fetch.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               PCSrc,
    input  logic [31:0]        BranchTarget,
    if_fetch_stage_if.master   imem,
    output logic [31:0]        IFID_Instruction,
    output logic [31:0]        IFID_PCPlus4,
    output logic               IFID_Valid
);
    localparam int unsigned XLEN = 32;

    localparam logic [1:0] ST_FETCH        = 2'd0;
    localparam logic [1:0] ST_HOLD         = 2'd1;
    localparam logic [1:0] ST_REDIRECT_PEND = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] skid_q, skid_d;
    logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
    logic [XLEN-1:0] pend_q, pend_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign target   = BranchTarget & ~XLEN'(3);

    assign imem.PC_out   = pc_q;
    assign imem.Imem_Req = req_q;

    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pc4_q;
    assign IFID_Valid       = valid_q;

    // State and pipeline registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_q      <= 1'b1;
            instr_q    <= NOP_INSTR;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            skid_q     <= '0;
            skid_pc4_q <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            skid_q     <= skid_d;
            skid_pc4_q <= skid_pc4_d;
            pend_q     <= pend_d;
        end
    end

    // Next-state / next-PC / IF/ID selection; priority is PCSrc > Stall > normal
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        skid_d     = skid_q;
        skid_pc4_d = skid_pc4_q;
        pend_d     = pend_q;

        case (state_q)
            ST_FETCH: begin
                if (PCSrc) begin
                    instr_d = NOP_INSTR;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    if (imem.Imem_Ready) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = ST_REDIRECT_PEND;
                    end
                end else if (Stall) begin
                    if (imem.Imem_Ready) begin
                        skid_d     = imem.Imem_Rdata;
                        skid_pc4_d = pc_plus4;
                        pc_d       = pc_plus4;
                        state_d    = ST_HOLD;
                    end
                end else if (imem.Imem_Ready) begin
                    instr_d = imem.Imem_Rdata;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                end else begin
                    instr_d = NOP_INSTR;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (PCSrc) begin
                    pc_d    = target;
                    instr_d = NOP_INSTR;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end else if (!Stall) begin
                    instr_d = skid_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_REDIRECT_PEND: begin
                instr_d = NOP_INSTR;
                pc4_d   = '0;
                valid_d = 1'b0;
                if (PCSrc) begin
                    pend_d = target;
                end
                // The outstanding wrong-path word is dropped; newest redirect wins
                if (imem.Imem_Ready) begin
                    pc_d    = PCSrc ? target : pend_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        req_d = (state_d != ST_HOLD);
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: step checks on PC/Req/Valid plus an IF/ID scoreboard.
`timescale 1ns/1ps
module tb_if_fetch_stage;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        ready;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] last_ifid = '0;

    if_fetch_stage_if bus ();

    // Memory model: word at address A is 0xDEAD_0000 | A[15:0]
    assign bus.Imem_Ready = ready;
    assign bus.Imem_Rdata = 32'hDEAD_0000 | {16'h0000, bus.PC_out[15:0]};

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .PCSrc            (PCSrc),
        .BranchTarget     (BranchTarget),
        .imem             (bus.master),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge
    task automatic step(input logic rst, input logic st, input logic src,
                        input logic [31:0] tgt, input logic rdy);
        Reset = rst; Stall = st; PCSrc = src; BranchTarget = tgt; ready = rdy;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc,
                             input logic req, input logic valid);
        chk({tag, "_pc"}, bus.PC_out, pc);
        chk({tag, "_req"}, {31'b0, bus.Imem_Req}, {31'b0, req});
        chk({tag, "_valid"}, {31'b0, IFID_Valid}, {31'b0, valid});
    endtask

    // Scoreboard monitor: every fresh valid IF/ID load must match the queue head;
    // during a stall the previously loaded entry must be held unchanged
    initial begin : monitor
        logic st_prev, rst_prev;
        logic [63:0] head;
        forever begin
            @(posedge Clk);
            st_prev  = Stall;
            rst_prev = Reset;
            #2;
            if (IFID_Valid === 1'b1 && !rst_prev) begin
                if (st_prev) begin
                    chk("ifid_hold_instr", IFID_Instruction, last_ifid[63:32]);
                    chk("ifid_hold_pc4", IFID_PCPlus4, last_ifid[31:0]);
                end else if (exp_q.size() == 0) begin
                    chk("ifid_unexpected_valid", IFID_Instruction, 32'hxxxx_xxxx);
                end else begin
                    head = exp_q.pop_front();
                    chk("ifid_instr", IFID_Instruction, head[63:32]);
                    chk("ifid_pc4", IFID_PCPlus4, head[31:0]);
                    last_ifid = head;
                end
            end
        end
    end

    initial begin
        Reset = 1'b1; Stall = 1'b0; PCSrc = 1'b0; BranchTarget = '0; ready = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0);
        chk_state("reset", 32'h0, 1'b1, 1'b0);
        chk("reset_instr", IFID_Instruction, 32'h0);
        chk("reset_pc4", IFID_PCPlus4, 32'h0);

        // Sequential fetch, one instruction per clock
        exp_q.push_back({32'hDEAD_0000, 32'h4});
        step(0, 0, 0, 0, 1); chk_state("seq0", 32'h4, 1'b1, 1'b1);
        exp_q.push_back({32'hDEAD_0004, 32'h8});
        step(0, 0, 0, 0, 1); chk_state("seq1", 32'h8, 1'b1, 1'b1);
        exp_q.push_back({32'hDEAD_0008, 32'hC});
        step(0, 0, 0, 0, 1); chk_state("seq2", 32'hC, 1'b1, 1'b1);

        // Redirect at PC=0x8 with same-cycle ready; target low bits masked
        step(1, 0, 0, 0, 0);
        exp_q.push_back({32'hDEAD_0000, 32'h4});
        step(0, 0, 0, 0, 1);
        exp_q.push_back({32'hDEAD_0004, 32'h8});
        step(0, 0, 0, 0, 1); chk_state("pre_br", 32'h8, 1'b1, 1'b1);
        step(0, 0, 1, 32'h103, 1); chk_state("br", 32'h100, 1'b1, 1'b0);
        exp_q.push_back({32'hDEAD_0100, 32'h104});
        step(0, 0, 0, 0, 1); chk_state("post_br", 32'h104, 1'b1, 1'b1);

        // Stall with fetched word parked in the skid
        step(0, 0, 1, 32'hC, 1);
        exp_q.push_back({32'hDEAD_000C, 32'h10});
        step(0, 0, 0, 0, 1); chk_state("pre_stall", 32'h10, 1'b1, 1'b1);
        step(0, 1, 0, 0, 1); chk_state("stall1", 32'h14, 1'b0, 1'b1);
        step(0, 1, 0, 0, 1); chk_state("stall2", 32'h14, 1'b0, 1'b1);
        step(0, 1, 0, 0, 1); chk_state("stall3", 32'h14, 1'b0, 1'b1);
        exp_q.push_back({32'hDEAD_0010, 32'h14});
        step(0, 0, 0, 0, 1); chk_state("unstall", 32'h14, 1'b1, 1'b1);
        exp_q.push_back({32'hDEAD_0014, 32'h18});
        step(0, 0, 0, 0, 1); chk_state("after_skid", 32'h18, 1'b1, 1'b1);

        // Redirect while fetch outstanding: PC frozen until ready
        step(0, 0, 1, 32'h20, 1); chk_state("to20", 32'h20, 1'b1, 1'b0);
        step(0, 0, 1, 32'h200, 0); chk_state("pend0", 32'h20, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0); chk_state("pend1", 32'h20, 1'b1, 1'b0);
        step(0, 1, 0, 0, 0); chk_state("pend2", 32'h20, 1'b1, 1'b0);
        step(0, 0, 0, 0, 1); chk_state("pend_done", 32'h200, 1'b1, 1'b0);
        exp_q.push_back({32'hDEAD_0200, 32'h204});
        step(0, 0, 0, 0, 1); chk_state("after_pend", 32'h204, 1'b1, 1'b1);

        // Newest redirect wins, before ready and in the ready cycle
        step(0, 0, 1, 32'h200, 0);
        step(0, 0, 1, 32'h300, 0); chk_state("pend_ovr", 32'h204, 1'b1, 1'b0);
        step(0, 0, 0, 0, 1); chk_state("ovr_done", 32'h300, 1'b1, 1'b0);
        step(0, 0, 1, 32'h400, 0);
        step(0, 0, 1, 32'h500, 1); chk_state("ovr_same", 32'h500, 1'b1, 1'b0);

        // Redirect in HOLD discards the skid
        step(0, 1, 0, 0, 1); chk_state("hold_a", 32'h504, 1'b0, 1'b0);
        step(0, 1, 1, 32'h600, 1); chk_state("hold_br", 32'h600, 1'b1, 1'b0);
        exp_q.push_back({32'hDEAD_0600, 32'h604});
        step(0, 0, 0, 0, 1); chk_state("after_hold_br", 32'h604, 1'b1, 1'b1);

        // Reset in HOLD and in REDIRECT_PEND
        step(0, 1, 0, 0, 1); chk_state("hold_b", 32'h608, 1'b0, 1'b1);
        step(1, 1, 0, 0, 1); chk_state("rst_hold", 32'h0, 1'b1, 1'b0);
        step(0, 0, 1, 32'h700, 0); chk_state("pend_r", 32'h0, 1'b1, 1'b0);
        step(1, 0, 1, 32'h800, 1); chk_state("rst_pend", 32'h0, 1'b1, 1'b0);
        exp_q.push_back({32'hDEAD_0000, 32'h4});
        step(0, 0, 0, 0, 1); chk_state("after_rst", 32'h4, 1'b1, 1'b1);

        // PC wrap at top of address space, then a not-ready bubble
        step(0, 0, 1, 32'hFFFF_FFFF, 1); chk_state("to_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
        exp_q.push_back({32'hDEAD_FFFC, 32'h0});
        step(0, 0, 0, 0, 1); chk_state("wrap", 32'h0, 1'b1, 1'b1);
        step(0, 0, 0, 0, 0); chk_state("no_ready", 32'h0, 1'b1, 1'b0);
        chk("bubble_instr", IFID_Instruction, 32'h0);

        step(0, 0, 0, 0, 0);
        #3;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
